// File: rtl/lap_stopwatch.sv
// Stopwatch core for a 4-digit seven-segment display: centisecond BCD time
// base, start/stop and lap buttons, a circular lap store and a multiplexed,
// registered display driver. Single clock, clock-enable based.
module lap_stopwatch #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_AW    = 2,
    parameter int MIN_MAX   = 9,
    parameter int SCAN_BITS = 13
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              show_lap,
    input  logic [LAP_AW-1:0] lap_sel,
    output logic [6:0]        seven_seg,
    output logic [3:0]        an,
    output logic              dp,
    output logic [7:0]        led,
    output logic              running,
    output logic [LAP_AW:0]   lap_count,
    output logic              wrapped
);
    localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int DEPTH     = 1 << LAP_AW;
    localparam int SW        = SCAN_BITS + 2;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC_MAX);
    localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
    localparam logic [3:0]        MIN_LAST   = 4'(MIN_MAX);
    localparam logic [LAP_AW-1:0] PTR_ONE    = LAP_AW'(1);
    localparam logic [LAP_AW:0]   CNT_ONE    = (LAP_AW + 1)'(1);
    localparam logic [LAP_AW:0]   CNT_FULL   = (LAP_AW + 1)'(DEPTH);
    localparam logic [SW-1:0]     SCAN_ONE   = SW'(1);

    logic              ss_reg, ss_prev_reg, lap_reg, lap_prev_reg;
    logic              running_reg, wrapped_reg;
    logic [PW-1:0]     presc_reg;
    logic [3:0]        cen_reg, dec_reg, s0_reg, s1_reg, min_reg;
    logic [LAP_AW-1:0] wr_ptr_reg;
    logic [LAP_AW:0]   lap_count_reg;
    logic [SW-1:0]     scan_reg;
    logic [19:0]       lap_mem [DEPTH];
    logic [6:0]        seg_reg;
    logic [3:0]        an_reg;
    logic              dp_reg;
    logic [7:0]        led_reg;

    logic              ss_pulse, lap_pulse, tick;
    logic [19:0]       live_time;

    assign ss_pulse  = ss_reg & ~ss_prev_reg;
    assign lap_pulse = lap_reg & ~lap_prev_reg;
    assign tick      = running_reg && (presc_reg == PRESC_LAST);
    assign live_time = {min_reg, s1_reg, s0_reg, dec_reg, cen_reg};

    // Button synchronising registers and their one-cycle-delayed copies.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            ss_reg       <= 1'b0;
            ss_prev_reg  <= 1'b0;
            lap_reg      <= 1'b0;
            lap_prev_reg <= 1'b0;
        end else begin
            ss_reg       <= start_stop;
            ss_prev_reg  <= ss_reg;
            lap_reg      <= lap;
            lap_prev_reg <= lap_reg;
        end
    end

    // Run flag and prescaler; the prescaler freezes while stopped.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            running_reg <= 1'b0;
            presc_reg   <= '0;
        end else begin
            running_reg <= running_reg ^ ss_pulse;
            if (running_reg)
                presc_reg <= tick ? '0 : presc_reg + PRESC_ONE;
        end
    end

    // BCD time chain with ripple carry and sticky wrap flag.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            cen_reg     <= '0;
            dec_reg     <= '0;
            s0_reg      <= '0;
            s1_reg      <= '0;
            min_reg     <= '0;
            wrapped_reg <= 1'b0;
        end else if (tick) begin
            if (cen_reg != 4'd9) begin
                cen_reg <= cen_reg + 4'd1;
            end else begin
                cen_reg <= '0;
                if (dec_reg != 4'd9) begin
                    dec_reg <= dec_reg + 4'd1;
                end else begin
                    dec_reg <= '0;
                    if (s0_reg != 4'd9) begin
                        s0_reg <= s0_reg + 4'd1;
                    end else begin
                        s0_reg <= '0;
                        if (s1_reg != 4'd5) begin
                            s1_reg <= s1_reg + 4'd1;
                        end else begin
                            s1_reg <= '0;
                            if (min_reg != MIN_LAST) begin
                                min_reg <= min_reg + 4'd1;
                            end else begin
                                min_reg     <= '0;
                                wrapped_reg <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Lap ring bookkeeping: write pointer and saturating lap count.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            lap_count_reg <= '0;
        end else if (lap_pulse) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (lap_count_reg != CNT_FULL)
                lap_count_reg <= lap_count_reg + CNT_ONE;
        end
    end

    // Lap storage; contents are hidden by lap_count after reset, so not cleared.
    always_ff @(posedge clk_50M) begin
        if (lap_pulse && !reset)
            lap_mem[wr_ptr_reg] <= live_time;
    end

    // Free-running digit scan counter.
    always_ff @(posedge clk_50M) begin
        if (reset)
            scan_reg <= '0;
        else
            scan_reg <= scan_reg + SCAN_ONE;
    end

    logic              lap_full, lap_valid, blank;
    logic [LAP_AW-1:0] phys_sel;
    logic [19:0]       src_time;
    logic [1:0]        digit_sel;
    logic [3:0]        nibble;
    logic [6:0]        seg_next;
    logic [7:0]        led_next;

    assign lap_full  = lap_count_reg[LAP_AW];
    assign phys_sel  = lap_full ? wr_ptr_reg + lap_sel : lap_sel;
    assign lap_valid = {1'b0, lap_sel} < lap_count_reg;
    assign blank     = show_lap & ~lap_valid;
    assign src_time  = show_lap ? lap_mem[phys_sel] : live_time;
    assign digit_sel = scan_reg[SW-1 -: 2];

    // Digit selection and segment decode for the current scan position.
    always_comb begin
        nibble = src_time[3:0];
        case (digit_sel)
            2'd0:    nibble = src_time[3:0];
            2'd1:    nibble = src_time[7:4];
            2'd2:    nibble = src_time[11:8];
            default: nibble = src_time[15:12];
        endcase
        case (nibble)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h7F;
        endcase
        if (blank)
            seg_next = 7'h7F;
    end

    // Minutes thermometer of the displayed source.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_led
            assign led_next[gi] = ~blank && (src_time[19:16] > 4'(gi));
        end
    endgenerate

    // Registered display outputs; segments and anodes move on the same edge.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            seg_reg <= 7'h40;
            an_reg  <= 4'b1110;
            dp_reg  <= 1'b1;
            led_reg <= 8'h00;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= ~(4'b0001 << digit_sel);
            dp_reg  <= blank | (digit_sel != 2'd2);
            led_reg <= led_next;
        end
    end

    assign seven_seg = seg_reg;
    assign an        = an_reg;
    assign dp        = dp_reg;
    assign led       = led_reg;
    assign running   = running_reg;
    assign lap_count = lap_count_reg;
    assign wrapped   = wrapped_reg;
endmodule
